// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin between ALU (A) and load unit (B)
// into a single registered register-file write port.
module wb_arbiter #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              sel
);

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_sel;
    logic              r_last_grant;

    logic              w_can_accept;
    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Grant logic: free slot, then round-robin on ties (last_grant loses).
    always_comb begin
        w_can_accept = 1'b0;
        w_a_ready    = 1'b0;
        w_b_ready    = 1'b0;
        w_in_xfer    = 1'b0;
        w_out_xfer   = 1'b0;
        w_addr       = a_addr;
        w_data       = a_data;

        w_can_accept = !r_wr_en || wr_ready;
        w_a_ready    = !rst && w_can_accept && a_valid
                       && (!b_valid || r_last_grant);
        w_b_ready    = !rst && w_can_accept && b_valid
                       && (!a_valid || !r_last_grant);
        w_in_xfer    = w_a_ready || w_b_ready;
        w_out_xfer   = r_wr_en && wr_ready;
        if (w_b_ready) begin
            w_addr = b_addr;
            w_data = b_data;
        end
    end

    // Held write and round-robin pointer; writes to $zero are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_in_xfer) begin
            r_last_grant <= w_b_ready;
            if (w_addr != '0) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
                r_sel     <= w_b_ready;
            end else begin
                r_wr_en <= 1'b0;
            end
        end else if (w_out_xfer) begin
            r_wr_en <= 1'b0;
        end
    end

    assign a_ready = w_a_ready;
    assign b_ready = w_b_ready;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign sel     = r_sel;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Parameters
REQ-001 The block SHALL take parameter DATA_W, default 20, as the width of the write-back data path.
REQ-002 The block SHALL take parameter ADDR_W, default 4, as the width of the register-file address.

Interface
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_valid  input  1  ALU result request.
REQ-006 a_data  input  DATA_W  ALU result.
REQ-007 a_addr  input  ADDR_W  ALU destination register.
REQ-008 a_ready  output  1  ALU request accepted this cycle.
REQ-009 b_valid  input  1  load-unit result request.
REQ-010 b_data  input  DATA_W  load result.
REQ-011 b_addr  input  ADDR_W  load destination register.
REQ-012 b_ready  output  1  load request accepted this cycle.
REQ-013 wr_en  output  1  register-file write valid.
REQ-014 wr_addr  output  ADDR_W  register-file write address.
REQ-015 wr_data  output  DATA_W  register-file write data.
REQ-016 wr_ready  input  1  register-file port consumes the write this cycle.
REQ-017 sel  output  1  source of the held write: 0 = A (ALU), 1 = B (load); this drives the write-back 2:1 mux select.

Function
REQ-018 A transfer on side X SHALL occur when x_valid and x_ready are both 1 in the same cycle.
REQ-019 Output-stage transfer SHALL occur when wr_en and wr_ready are both 1 in the same cycle.
REQ-020 can_accept SHALL be (wr_en == 0) or (wr_ready == 1); this allows one write per cycle at full throughput.
REQ-021 a_ready and b_ready SHALL be combinational from can_accept, both valid inputs, and last_grant.
- a_ready and b_ready SHALL never both be 1.
- Each SHALL be 0 when can_accept is 0.
REQ-022 Only one valid input high: that side SHALL be granted when can_accept is 1.
REQ-023 Both valid inputs high: the side not recorded in last_grant SHALL be granted (round-robin).
REQ-024 last_grant SHALL update to the granted side on every input transfer, including dropped writes.
REQ-025 last_grant SHALL hold its value in cycles with no input transfer.
REQ-026 On an input transfer with addr != 0, the next cycle SHALL show:
- wr_en = 1;
- wr_addr and wr_data = the granted side's address and data;
- sel = granted side.
This gives latency of exactly 1 cycle.
REQ-027 On an input transfer with addr == 0 (register $zero), the handshake SHALL complete and the write SHALL be discarded.
- wr_en next cycle SHALL be 0 unless REQ-026 applies.
- wr_addr, wr_data and sel SHALL hold their values.
REQ-028 While wr_en = 1 and wr_ready = 0, wr_addr, wr_data and sel SHALL hold stable.
REQ-029 An output transfer with no input transfer in the same cycle SHALL clear wr_en next cycle.
REQ-030 An output transfer and an input transfer in the same cycle SHALL replace the held write with the new one; no bubble SHALL be inserted.
REQ-031 Requesters SHALL hold x_valid, x_data and x_addr stable until accepted; the bench SHALL check this rule on every requester.
REQ-032 A non-granted requester SHALL receive x_ready = 0 and retains its request; no request SHALL be lost or duplicated.
REQ-033 No combinational path SHALL exist from wr_ready to wr_en, wr_addr, wr_data or sel.

Reset
REQ-034 With rst = 1 at a rising edge, the following SHALL all be 0 on the next cycle:
- wr_en, wr_addr, wr_data and sel;
- last_grant SHALL be 1 (B), so A wins the first tie.
REQ-035 While rst = 1, a_ready and b_ready SHALL be 0.
REQ-036 rst asserted while a write is held un-consumed (mid-operation) SHALL discard that write; no transfer SHALL be reported.

Verification
REQ-037 After reset, both sides valid every cycle, wr_ready = 1, a_addr = 3 / a_data = 0x12345, b_addr = 5 / b_data = 0xABCDE:
- grants SHALL alternate A, B, A, B;
- wr_en SHALL be 1 every cycle from cycle 2;
- sel SHALL be 0, 1, 0, 1.
REQ-038 Only A valid, wr_ready = 1, addr = 7, data = 0xFFFFF -> next cycle wr_en = 1, wr_addr = 7, wr_data = 0xFFFFF, sel = 0.
REQ-039 B valid with addr 0, data 0x00001 -> b_ready = 1; wr_en stays 0; next tie SHALL go to A.
REQ-040 Held write plus wr_ready = 0 for 3 cycles with A valid:
- a_ready SHALL be 0 for those 3 cycles;
- wr_* SHALL hold stable;
- A SHALL be accepted in the cycle wr_ready rises.
REQ-041 Held write (wr_en = 1, wr_ready = 0), then rst pulsed for 1 cycle -> wr_en = 0, wr_addr = 0, wr_data = 0, sel = 0; the first subsequent tie SHALL go to A.
REQ-042 Random valid/wr_ready traffic for 10,000 cycles, checked by a scoreboard:
- every accepted nonzero-address request SHALL appear exactly once on the write port, in acceptance order;
- no side SHALL wait more than 1 grant while the other is granted.
